// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; pops on resolve and emits a
// registered predictor-update packet, with misprediction recovery and statistics.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 10,
    parameter int GH_W  = 12,
    parameter int CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enq_valid_i,
    output logic                       enq_ready_o,
    input  logic [PC_W-1:0]            enq_pc_i,
    input  logic                       enq_pred_i,
    input  logic                       enq_local_pred_i,
    input  logic                       enq_global_pred_i,
    input  logic [GH_W-1:0]            enq_ghist_i,
    input  logic                       res_valid_i,
    input  logic                       res_taken_i,
    input  logic                       flush_i,
    output logic                       upd_valid_o,
    output logic [PC_W-1:0]            upd_pc_o,
    output logic                       upd_taken_o,
    output logic                       upd_pred_o,
    output logic                       upd_local_ok_o,
    output logic                       upd_global_ok_o,
    output logic [GH_W-1:0]            upd_ghist_o,
    output logic                       mispredict_o,
    output logic [GH_W-1:0]            recover_ghist_o,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic [CNT_W-1:0]           branch_count_o,
    output logic [CNT_W-1:0]           mispredict_count_o,
    output logic                       underflow_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int EW = PC_W + 3 + GH_W;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic             upd_valid_q, mispredict_q, underflow_q;
    logic [PC_W-1:0]  upd_pc_q;
    logic             upd_taken_q, upd_pred_q, upd_local_ok_q, upd_global_ok_q;
    logic [GH_W-1:0]  upd_ghist_q, recover_ghist_q;

    logic [EW-1:0]    head_entry;
    logic [PC_W-1:0]  h_pc;
    logic             h_pred, h_lp, h_gp;
    logic [GH_W-1:0]  h_gh;
    logic             full, do_res, mis, do_enq;

    always_comb begin
        head_entry = mem_q[head_q];
        h_pc       = head_entry[EW-1 -: PC_W];
        h_pred     = head_entry[GH_W+2];
        h_lp       = head_entry[GH_W+1];
        h_gp       = head_entry[GH_W];
        h_gh       = head_entry[GH_W-1:0];
    end

    // Flush dominates everything; a mispredicted pop squashes the same-cycle enqueue.
    assign full   = (occ_q == OW'(DEPTH));
    assign do_res = res_valid_i && (occ_q != '0) && !flush_i;
    assign mis    = do_res && (h_pred != res_taken_i);
    assign do_enq = enq_valid_i && !full && !flush_i && !mis;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush_i) begin
            tail_d = head_q;
            occ_d  = '0;
        end else if (mis) begin
            head_d = head_q + AW'(1);
            tail_d = head_q + AW'(1);
            occ_d  = '0;
        end else begin
            if (do_res) head_d = head_q + AW'(1);
            if (do_enq) tail_d = tail_q + AW'(1);
            occ_d = occ_q + OW'(do_enq) - OW'(do_res);
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (do_res && (branch_count_q != '1))
            branch_count_d = branch_count_q + CNT_W'(1);
        if (mis && (mispredict_count_q != '1))
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end

    // Entry storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (do_enq)
            mem_q[tail_q] <= {enq_pc_i, enq_pred_i, enq_local_pred_i, enq_global_pred_i, enq_ghist_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q             <= '0;
            tail_q             <= '0;
            occ_q              <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            upd_valid_q        <= 1'b0;
            mispredict_q       <= 1'b0;
            underflow_q        <= 1'b0;
            upd_pc_q           <= '0;
            upd_taken_q        <= 1'b0;
            upd_pred_q         <= 1'b0;
            upd_local_ok_q     <= 1'b0;
            upd_global_ok_q    <= 1'b0;
            upd_ghist_q        <= '0;
            recover_ghist_q    <= '0;
        end else begin
            head_q             <= head_d;
            tail_q             <= tail_d;
            occ_q              <= occ_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            upd_valid_q        <= do_res;
            mispredict_q       <= mis;
            underflow_q        <= underflow_q | (res_valid_i && (occ_q == '0));
            if (do_res) begin
                upd_pc_q        <= h_pc;
                upd_taken_q     <= res_taken_i;
                upd_pred_q      <= h_pred;
                upd_local_ok_q  <= (h_lp == res_taken_i);
                upd_global_ok_q <= (h_gp == res_taken_i);
                upd_ghist_q     <= h_gh;
                recover_ghist_q <= {h_gh[GH_W-2:0], res_taken_i};
            end
        end
    end

    assign enq_ready_o        = !full;
    assign upd_valid_o        = upd_valid_q;
    assign upd_pc_o           = upd_pc_q;
    assign upd_taken_o        = upd_taken_q;
    assign upd_pred_o         = upd_pred_q;
    assign upd_local_ok_o     = upd_local_ok_q;
    assign upd_global_ok_o    = upd_global_ok_q;
    assign upd_ghist_o        = upd_ghist_q;
    assign mispredict_o       = mispredict_q;
    assign recover_ghist_o    = recover_ghist_q;
    assign occupancy_o        = occ_q;
    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;
    assign underflow_err_o    = underflow_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: stimulus pushes expected update
// packets, a negedge monitor pops and compares whenever upd_valid is seen.
module tb_branch_resolve_queue;
    localparam int DEPTH = 8;
    localparam int PC_W  = 10;
    localparam int GH_W  = 12;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enq_valid = 1'b0, enq_pred = 1'b0, enq_lp = 1'b0, enq_gp = 1'b0;
    logic [PC_W-1:0] enq_pc = '0;
    logic [GH_W-1:0] enq_gh = '0;
    logic res_valid = 1'b0, res_taken = 1'b0, flush = 1'b0;
    logic enq_ready, upd_valid, upd_taken, upd_pred, upd_lok, upd_gok, mispredict, underflow;
    logic [PC_W-1:0] upd_pc;
    logic [GH_W-1:0] upd_gh, recover_gh;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CNT_W-1:0] branch_count, mispredict_count;

    always #5 clk = ~clk;

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .GH_W(GH_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .enq_valid_i(enq_valid), .enq_ready_o(enq_ready), .enq_pc_i(enq_pc),
        .enq_pred_i(enq_pred), .enq_local_pred_i(enq_lp), .enq_global_pred_i(enq_gp),
        .enq_ghist_i(enq_gh), .res_valid_i(res_valid), .res_taken_i(res_taken),
        .flush_i(flush), .upd_valid_o(upd_valid), .upd_pc_o(upd_pc),
        .upd_taken_o(upd_taken), .upd_pred_o(upd_pred), .upd_local_ok_o(upd_lok),
        .upd_global_ok_o(upd_gok), .upd_ghist_o(upd_gh), .mispredict_o(mispredict),
        .recover_ghist_o(recover_gh), .occupancy_o(occupancy),
        .branch_count_o(branch_count), .mispredict_count_o(mispredict_count),
        .underflow_err_o(underflow)
    );

    typedef struct {
        logic [PC_W-1:0] pc;
        logic pred, lp, gp;
        logic [GH_W-1:0] gh;
    } ent_t;
    typedef struct {
        logic [PC_W-1:0] pc;
        logic taken, pred, lok, gok, mis;
        logic [GH_W-1:0] gh, rec;
    } pkt_t;

    ent_t model[$];
    pkt_t expq[$];
    int total = 0;
    int bad = 0;
    logic [CNT_W-1:0] exp_br = '0;
    logic [CNT_W-1:0] exp_mis = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; expectations derived from the reference queue before the edge.
    task automatic cyc(input bit ev, input logic [PC_W-1:0] pc, input bit pred, input bit lp,
                       input bit gp, input logic [GH_W-1:0] gh, input bit rv, input bit tk,
                       input bit fl);
        bit accept, mis;
        ent_t e;
        pkt_t p;
        enq_valid = ev; enq_pc = pc; enq_pred = pred; enq_lp = lp; enq_gp = gp; enq_gh = gh;
        res_valid = rv; res_taken = tk; flush = fl;
        accept = ev && (model.size() < DEPTH) && !fl;
        mis = 1'b0;
        if (fl) begin
            model.delete();
        end else if (rv && model.size() > 0) begin
            e = model.pop_front();
            p.pc = e.pc; p.taken = tk; p.pred = e.pred;
            p.lok = (e.lp == tk); p.gok = (e.gp == tk);
            p.gh = e.gh; p.mis = (e.pred != tk);
            p.rec = {e.gh[GH_W-2:0], tk};
            mis = p.mis;
            expq.push_back(p);
            if (exp_br != '1) exp_br++;
            if (mis) begin
                if (exp_mis != '1) exp_mis++;
                model.delete();
            end
        end
        if (accept && !mis) model.push_back('{pc, pred, lp, gp, gh});
        @(posedge clk);
        #1;
        enq_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle();
        cyc(0, '0, 0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_occupancy"}, 32'(occupancy), 32'(model.size()));
        chk({tag, "_enq_ready"}, 32'(enq_ready), 32'(model.size() != DEPTH));
        chk({tag, "_branch_count"}, 32'(branch_count), 32'(exp_br));
        chk({tag, "_mispredict_count"}, 32'(mispredict_count), 32'(exp_mis));
    endtask

    always @(negedge clk) begin
        if (rst_n && upd_valid) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_update: got upd_pc=0x%0h expected no upd_valid", upd_pc);
            end else begin
                pkt_t p;
                p = expq.pop_front();
                $display("update pc=0x%0h taken=%0d mis=%0d", upd_pc, upd_taken, mispredict);
                chk("upd_pc", 32'(upd_pc), 32'(p.pc));
                chk("upd_taken", 32'(upd_taken), 32'(p.taken));
                chk("upd_pred", 32'(upd_pred), 32'(p.pred));
                chk("upd_local_ok", 32'(upd_lok), 32'(p.lok));
                chk("upd_global_ok", 32'(upd_gok), 32'(p.gok));
                chk("upd_ghist", 32'(upd_gh), 32'(p.gh));
                chk("mispredict", 32'(mispredict), 32'(p.mis));
                chk("recover_ghist", 32'(recover_gh), 32'(p.rec));
            end
        end
    end

    initial begin
        #12;
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_enq_ready", 32'(enq_ready), 1);
        chk("rst_upd_valid", 32'(upd_valid), 0);
        chk("rst_mispredict", 32'(mispredict), 0);
        chk("rst_upd_pc", 32'(upd_pc), 0);
        chk("rst_recover", 32'(recover_gh), 0);
        chk("rst_counts", 32'({branch_count, mispredict_count}), 0);
        chk("rst_underflow", 32'(underflow), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single correct resolve, hand-checked packet
        cyc(1, 10'h005, 1, 1, 0, 12'h0A5, 0, 0, 0);
        cyc(0, '0, 0, 0, 0, '0, 1, 1, 0);
        chk("t1_upd_valid", 32'(upd_valid), 1);
        chk("t1_upd_pc", 32'(upd_pc), 32'h005);
        chk("t1_local_ok", 32'(upd_lok), 1);
        chk("t1_global_ok", 32'(upd_gok), 0);
        chk("t1_mispredict", 32'(mispredict), 0);
        chk("t1_branch_count", 32'(branch_count), 1);
        idle();

        // Fill to DEPTH, refuse a 9th, drain in order across the pointer wrap
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 10'(10'h010 + i), i[0], i[1], i[2], 12'(12'h100 + i), 0, 0, 0);
        chk("t2_enq_ready_full", 32'(enq_ready), 0);
        chk("t2_occupancy_full", 32'(occupancy), 8);
        cyc(1, 10'h3FF, 1, 1, 1, 12'hFFF, 0, 0, 0);
        chk("t2_occupancy_9th", 32'(occupancy), 8);
        for (int i = 0; i < DEPTH; i++)
            cyc(0, '0, 0, 0, 0, '0, 1, i[0], 0);
        idle();
        check_state("t2");

        // Mispredict on oldest of 4 with a same-cycle wrong-path enqueue
        for (int i = 0; i < 4; i++)
            cyc(1, 10'(10'h020 + i), 1, 0, 1, 12'(12'h8A1 + i), 0, 0, 0);
        cyc(1, 10'h2AA, 1, 1, 1, 12'h555, 1, 0, 0);
        chk("t3_mispredict", 32'(mispredict), 1);
        chk("t3_recover", 32'(recover_gh), 32'h142);
        chk("t3_occupancy", 32'(occupancy), 0);
        chk("t3_mis_count", 32'(mispredict_count), 1);
        cyc(1, 10'h031, 0, 0, 0, 12'h031, 0, 0, 0);
        cyc(0, '0, 0, 0, 0, '0, 1, 0, 0);
        chk("t3_after_pc", 32'(upd_pc), 32'h031);
        idle();
        check_state("t3");

        // Full queue: correct resolve plus enqueue attempt -> enqueue refused
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 10'(10'h040 + i), 0, 1, 0, 12'(12'h040 + i), 0, 0, 0);
        cyc(1, 10'h3EE, 1, 1, 1, 12'h3EE, 1, 0, 0);
        chk("t4_occupancy", 32'(occupancy), 7);
        for (int i = 0; i < DEPTH - 1; i++)
            cyc(0, '0, 0, 0, 0, '0, 1, 0, 0);
        idle();
        check_state("t4");

        // Resolve while empty sets sticky underflow; flush with 5 held plus res_valid
        cyc(0, '0, 0, 0, 0, '0, 1, 1, 0);
        chk("t5_upd_valid_empty", 32'(upd_valid), 0);
        chk("t5_underflow", 32'(underflow), 1);
        idle();
        idle();
        chk("t5_underflow_sticky", 32'(underflow), 1);
        for (int i = 0; i < 5; i++)
            cyc(1, 10'(10'h060 + i), 1, 1, 1, 12'(12'h060 + i), 0, 0, 0);
        chk("t5_occupancy_5", 32'(occupancy), 5);
        cyc(1, 10'h070, 1, 1, 1, 12'h070, 1, 1, 1);
        chk("t5_flush_occupancy", 32'(occupancy), 0);
        chk("t5_flush_upd_valid", 32'(upd_valid), 0);
        idle();
        check_state("t5");

        // Mispredict counter saturation
        force dut.mispredict_count_q = 16'hFFFE;
        #1;
        release dut.mispredict_count_q;
        exp_mis = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 10'(10'h080 + k), 1, 0, 0, 12'(12'h080 + k), 0, 0, 0);
            cyc(0, '0, 0, 0, 0, '0, 1, 0, 0);
            chk("t6_mis_count_sat", 32'(mispredict_count), 32'hFFFF);
        end
        idle();
        check_state("t6");

        // Reset mid-stream with a resolve pending: everything clears, no packet later
        for (int i = 0; i < 3; i++)
            cyc(1, 10'(10'h090 + i), 1, 1, 1, 12'(12'h090 + i), 0, 0, 0);
        res_valid = 1'b1;
        res_taken = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_occupancy", 32'(occupancy), 0);
        chk("t7_rst_enq_ready", 32'(enq_ready), 1);
        chk("t7_rst_upd_valid", 32'(upd_valid), 0);
        chk("t7_rst_upd_pc", 32'(upd_pc), 0);
        chk("t7_rst_recover", 32'(recover_gh), 0);
        chk("t7_rst_counts", 32'({branch_count, mispredict_count}), 0);
        chk("t7_rst_underflow", 32'(underflow), 0);
        model.delete();
        exp_br = '0;
        exp_mis = '0;
        @(negedge clk);
        res_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t7_post_upd_valid", 32'(upd_valid), 0);
        idle();
        check_state("t7");

        chk("scoreboard_drained", 32'(expq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
